keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 196 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with a synchronizer, scan divider,
// per-scan debounce FSM and key decode into digit/operator/execute/clear strobes.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-emit held digit/operator keys
// every REPEAT_SCANS scans.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       digit_pulse,
  output logic [3:0] digit_val,
  output logic       op_pulse,
  output logic [1:0] op_code,
  output logic       execute_pulse,
  output logic       clear_pulse,
  output logic       key_held
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE = 2'd0, DEBOUNCE = 2'd1, HELD = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [3:0]       col_meta, col_sync;
  logic [DIV_W-1:0] div;
  logic [1:0]       row_idx;
  logic [15:0]      snapshot;
  logic             scan_done;
  logic [4:0]       ones;
  logic [3:0]       idx;
  logic             scan_single, scan_none;
  logic [3:0]       cand, cnt, cnt_inc;
  logic [1:0]       key_row, key_col;
  logic             is_op, is_clear, is_exec, is_digit;
  logic [3:0]       dec_digit;
  logic             fire;

  // Two-flop synchronizer for the asynchronous column lines
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  // Row divider: hold each row for SCAN_DIV cycles, capture its columns at terminal count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div       <= '0;
      row_idx   <= 2'd0;
      row_n     <= 4'b1110;
      snapshot  <= 16'h0000;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (div == DIV_LAST) begin
        div                              <= '0;
        snapshot[{row_idx, 2'b00} +: 4]  <= ~col_sync;
        row_idx                          <= row_idx + 2'd1;
        row_n                            <= ~(4'b0001 << (row_idx + 2'd1));
        scan_done                        <= (row_idx == 2'd3);
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  // Scan classification: count pressed keys and remember the position of one of them
  always_comb begin
    ones = 5'd0;
    idx  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snapshot[i]) begin
        ones = ones + 5'd1;
        idx  = 4'(i);
      end
    end
    scan_single = (ones == 5'd1);
    scan_none   = (ones == 5'd0);
    cnt_inc     = cnt + 4'd1;
  end

  // Key decode of the single pressed position
  always_comb begin
    key_row   = idx[3:2];
    key_col   = idx[1:0];
    is_op     = (key_col == 2'd3);
    is_clear  = (key_row == 2'd3) && (key_col == 2'd0);
    is_exec   = (key_row == 2'd3) && (key_col == 2'd2);
    is_digit  = !is_op && !is_clear && !is_exec;
    dec_digit = (key_row == 2'd3) ? 4'd0 : (4'(key_row) * 4'd3 + 4'(key_col) + 4'd1);
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state, evaluated once per completed scan
  always_comb begin
    state_nxt = state;
    if (scan_done) begin
      case (state)
        IDLE:     if (scan_single) state_nxt = (DEB_LAST == 4'd1) ? HELD : DEBOUNCE;
        DEBOUNCE: begin
          if (scan_single && (idx == cand)) begin
            if (cnt_inc == DEB_LAST) state_nxt = HELD;
          end else begin
            state_nxt = IDLE;
          end
        end
        HELD:     if (scan_none && (cnt_inc == DEB_LAST)) state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Candidate key and shared press/release scan counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand <= 4'd0;
      cnt  <= 4'd0;
    end else if (scan_done) begin
      case (state)
        IDLE: begin
          if (scan_single) begin
            cand <= idx;
            cnt  <= (state_nxt == HELD) ? 4'd0 : 4'd1;
          end
        end
        DEBOUNCE: cnt <= (state_nxt == DEBOUNCE) ? cnt_inc : 4'd0;
        HELD:     cnt <= (scan_none && (state_nxt == HELD)) ? cnt_inc : 4'd0;
        default:  cnt <= 4'd0;
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [7:0] REP_LAST = 8'(REPEAT_SCANS - 1);
  logic [7:0] rep;

  // Repeat counter: consecutive scans of the same held key
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep <= 8'd0;
    end else if (scan_done) begin
      if ((state == HELD) && scan_single && (idx == cand))
        rep <= (rep == REP_LAST) ? 8'd0 : rep + 8'd1;
      else
        rep <= 8'd0;
    end
  end
`endif

  // FSM output: strobe on acceptance (and on repeat when built in)
  always_comb begin
    fire = (state != HELD) && (state_nxt == HELD);
`ifdef KEYPAD_AUTOREPEAT_EN
    if (scan_done && (state == HELD) && scan_single && (idx == cand) &&
        (rep == REP_LAST) && !is_clear && !is_exec)
      fire = 1'b1;
`endif
  end

  // Registered strobes, key values and held flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_pulse   <= 1'b0;
      digit_val     <= 4'd0;
      op_pulse      <= 1'b0;
      op_code       <= 2'd0;
      execute_pulse <= 1'b0;
      clear_pulse   <= 1'b0;
      key_held      <= 1'b0;
    end else begin
      digit_pulse   <= fire && is_digit;
      op_pulse      <= fire && is_op;
      execute_pulse <= fire && is_exec;
      clear_pulse   <= fire && is_clear;
      key_held      <= (state_nxt == HELD);
      if (fire && is_digit) digit_val <= dec_digit;
      if (fire && is_op)    op_code   <= key_row;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and randomized keypad scans against a scan-level model.
module tb_keypad_scanner;

  localparam int unsigned SD = 4;
  localparam int DS = 2;
  localparam int RS = 3;
  localparam int SCAN_CYC = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic        digit_pulse, op_pulse, execute_pulse, clear_pulse, key_held;
  logic [3:0]  digit_val;
  logic [1:0]  op_code;
  logic [15:0] keys;

  int errors = 0;
  int checks = 0;
  int obs_digit, obs_op, obs_exec, obs_clear, obs_multi;
  int tot_digit = 0, tot_op = 0, tot_exec = 0, tot_clear = 0;
  int base_digit, base_op, base_exec, base_clear;

  // Scan-level model state
  string keymap = "123A456B789C*0#D";
  bit    m_held;
  int    m_cand, m_run, m_rel, m_rep, m_digit, m_op;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS), .REPEAT_SCANS(RS)) dut (
    .clk(clk), .reset(reset), .col_n(col_n), .row_n(row_n),
    .digit_pulse(digit_pulse), .digit_val(digit_val),
    .op_pulse(op_pulse), .op_code(op_code),
    .execute_pulse(execute_pulse), .clear_pulse(clear_pulse),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (row_n[r] == 1'b0)
        for (int c = 0; c < 4; c++)
          if (keys[4*r+c]) col_n[c] = 1'b0;
  end

  // Pulse monitor
  always @(negedge clk) begin
    if (digit_pulse === 1'b1)   obs_digit++;
    if (op_pulse === 1'b1)      obs_op++;
    if (execute_pulse === 1'b1) obs_exec++;
    if (clear_pulse === 1'b1)   obs_clear++;
    if ((int'(digit_pulse) + int'(op_pulse) + int'(execute_pulse) + int'(clear_pulse)) > 1)
      obs_multi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_held = 1'b0; m_cand = 0; m_run = 0; m_rel = 0; m_rep = 0; m_digit = 0; m_op = 0;
  endtask

  // Returns 1 digit, 2 operator, 3 execute, 4 clear
  function automatic int emit(input int k);
    byte ch;
    ch = keymap[k];
    if (ch >= "0" && ch <= "9") begin m_digit = int'(ch) - int'("0"); return 1; end
    if (ch >= "A" && ch <= "D") begin m_op = int'(ch) - int'("A"); return 2; end
    if (ch == "#") return 3;
    return 4;
  endfunction

  // One scan of the model: returns the strobe kind this scan should produce (0 = none)
  task automatic model_scan(input logic [15:0] m, output int kind);
    int n, k;
    byte ch;
    n = $countones(m);
    k = -1;
    for (int i = 0; i < 16; i++) if (m[i]) k = i;
    kind = 0;
    if (!m_held) begin
      if (n == 1 && m_run > 0 && k == m_cand) m_run++;
      else if (n == 1 && m_run == 0) begin m_cand = k; m_run = 1; end
      else m_run = 0;
      if (m_run == DS) begin
        m_held = 1'b1; m_run = 0; m_rel = 0; m_rep = 0;
        kind = emit(m_cand);
      end
    end else if (n == 0) begin
      m_rel++;
      m_rep = 0;
      if (m_rel == DS) m_held = 1'b0;
    end else begin
      m_rel = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
      if (n == 1 && k == m_cand) begin
        m_rep++;
        if (m_rep == RS) begin
          m_rep = 0;
          ch = keymap[m_cand];
          if (ch != "*" && ch != "#") kind = emit(m_cand);
        end
      end else begin
        m_rep = 0;
      end
`else
      ch = keymap[0];
      m_rep = int'(ch) * 0;
`endif
    end
  endtask

  task automatic clear_obs();
    obs_digit = 0; obs_op = 0; obs_exec = 0; obs_clear = 0; obs_multi = 0;
  endtask

  // Wait for row 0 to start, then land one cycle into it (keys may change from here)
  task automatic align();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      prev = row_n;
      @(negedge clk);
      if (prev == 4'b0111 && row_n == 4'b1110) found = 1'b1;
    end
    check("align_timeout", 32'(found), 32'd1);
    @(negedge clk);
    #1;
    clear_obs();
  endtask

  // Present a key mask for one scan; checks the result of that scan
  task automatic scan_step(input logic [15:0] m);
    int ek;
    keys = m;
    repeat (SCAN_CYC) @(negedge clk);
    #1;
    model_scan(m, ek);
    check("digit_pulse_cnt", obs_digit, (ek == 1) ? 1 : 0);
    check("op_pulse_cnt",    obs_op,    (ek == 2) ? 1 : 0);
    check("exec_pulse_cnt",  obs_exec,  (ek == 3) ? 1 : 0);
    check("clear_pulse_cnt", obs_clear, (ek == 4) ? 1 : 0);
    check("multi_pulse",     obs_multi, 0);
    check("digit_val",       32'(digit_val), m_digit);
    check("op_code",         32'(op_code),   m_op);
    check("key_held",        32'(key_held),  32'(m_held));
    tot_digit += obs_digit; tot_op += obs_op; tot_exec += obs_exec; tot_clear += obs_clear;
    clear_obs();
  endtask

  task automatic hold(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) scan_step(m);
  endtask

  task automatic mark();
    base_digit = tot_digit; base_op = tot_op; base_exec = tot_exec; base_clear = tot_clear;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row_n"}, 32'(row_n), 32'hE);
    check({tag, "_pulses"}, 32'({digit_pulse, op_pulse, execute_pulse, clear_pulse}), 32'd0);
    check({tag, "_digit_val"}, 32'(digit_val), 32'd0);
    check({tag, "_op_code"}, 32'(op_code), 32'd0);
    check({tag, "_key_held"}, 32'(key_held), 32'd0);
  endtask

  initial begin
    logic [15:0] m;
    int sel, a, b;
    reset = 1'b1;
    keys  = 16'h0000;
    clear_obs();
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    align();

    // '7' held 5 scans then released
    mark();
    hold(16'h0100, 5);
    hold(16'h0000, 3);
    check("seq7_digits", tot_digit - base_digit, 1);
    check("seq7_val", 32'(digit_val), 32'd7);

    // 'C' one scan, gap, three scans
    mark();
    hold(16'h0800, 1);
    hold(16'h0000, 1);
    hold(16'h0800, 3);
    hold(16'h0000, 3);
    check("seqC_ops", tot_op - base_op, 1);
    check("seqC_code", 32'(op_code), 32'd2);

    // '5' and '6' together
    mark();
    hold(16'h0060, 4);
    hold(16'h0000, 2);
    check("seq56_pulses", (tot_digit - base_digit) + (tot_op - base_op), 0);

    // '#' accepted, reset during HELD
    mark();
    hold(16'h4000, 3);
    check("seqH_exec1", tot_exec - base_exec, 1);
    @(negedge clk);
    reset = 1'b1;
    keys  = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("midhold");
    reset = 1'b0;
    model_reset();
    align();
    mark();
    hold(16'h4000, 2);
    hold(16'h0000, 3);
    check("seqH_exec2", tot_exec - base_exec, 1);

    // Reset mid-debounce discards the candidate
    hold(16'h0001, 1);
    @(negedge clk);
    reset = 1'b1;
    keys  = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("middeb");
    reset = 1'b0;
    model_reset();
    align();
    hold(16'h0000, 2);

    // Chatter on '0'
    mark();
    for (int i = 0; i < 4; i++) begin
      scan_step(16'h2000);
      scan_step(16'h0000);
    end
    check("chatter_pulses", tot_digit - base_digit, 0);

    // Other key pressed while '1' is held
    mark();
    hold(16'h0001, 3);
    hold(16'h0002, 3);
    hold(16'h0000, 2);
    check("other_key_digits", tot_digit - base_digit, 1);
    check("other_key_val", 32'(digit_val), 32'd1);

    // Long holds of '3' and '*'
    mark();
    hold(16'h0004, 11);
    hold(16'h0000, 3);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("hold3_digits", tot_digit - base_digit, 4);
`else
    check("hold3_digits", tot_digit - base_digit, 1);
`endif
    check("hold3_val", 32'(digit_val), 32'd3);
    mark();
    hold(16'h1000, 11);
    hold(16'h0000, 3);
    check("holdstar_clears", tot_clear - base_clear, 1);

    // Randomized scan sequence
    m = 16'h0000;
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 3) begin
        m = m;
      end else if (sel <= 5) begin
        m = 16'h0000;
      end else if (sel <= 7) begin
        m = 16'(1) << $urandom_range(0, 15);
      end else begin
        a = int'($urandom_range(0, 15));
        b = (a + 1 + int'($urandom_range(0, 14))) % 16;
        m = (16'(1) << a) | (16'(1) << b);
      end
      scan_step(m);
    end
    hold(16'h0000, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
